// File: rtl/local_store_banked_if.sv
// Requester port bundle for local_store_banked: one instance per requester.
//   req_valid/req_ready : request handshake (ready is combinational in the store)
//   we                  : 1 = write, 0 = read
//   addr                : byte address, low log2(LINE_BYTES) bits ignored
//   wdata/rdata         : one line, big-endian, byte 0 in bits [0:7]
//   be                  : byte enables, bit 0 = byte 0
//   rvalid              : one-cycle pulse after an accepted read
// Modports: master = requester side, slave = store side.
interface local_store_banked_if #(
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned LINE_BYTES = 16
);
  localparam int unsigned DATA_W = LINE_BYTES * 8;

  logic                   req_valid;
  logic                   req_ready;
  logic                   we;
  logic [ADDR_W-1:0]      addr;
  logic [0:DATA_W-1]      wdata;
  logic [0:LINE_BYTES-1]  be;
  logic                   rvalid;
  logic [0:DATA_W-1]      rdata;

  modport master (
    output req_valid, we, addr, wdata, be,
    input  req_ready, rvalid, rdata
  );

  modport slave (
    input  req_valid, we, addr, wdata, be,
    output req_ready, rvalid, rdata
  );
endinterface

// File: rtl/local_store_banked.sv
// Line-organised local store with two requester ports (ls = SPU load/store,
// dma = DMA/preload), one access per cycle, registered reads, per-byte write
// enables and a multi-cycle hardware clear sequencer.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   ls, dma      : local_store_banked_if.slave requester ports
//   clear_start  : pulse in IDLE to zero the whole store
//   busy         : clear in progress (requests are not accepted)
// Optional build macro LS_DMA_ANTISTARVE_EN: after the DMA port has waited three
// cycles, the next cycle is granted to DMA and load/store is stalled.
module local_store_banked #(
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned LINE_BYTES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  local_store_banked_if.slave   ls,
  local_store_banked_if.slave   dma,
  input  logic                  clear_start,
  output logic                  busy
);

  localparam int unsigned DATA_W = LINE_BYTES * 8;
  localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
  localparam int unsigned IDX_W  = ADDR_W - OFF_W;
  localparam int unsigned DEPTH  = 2 ** IDX_W;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]            state, state_nxt;
  logic [IDX_W-1:0]      clear_ptr, clear_ptr_nxt;
  logic [0:DATA_W-1]     mem [DEPTH];

  logic                  idle;
  logic                  force_dma;
  logic                  ls_gnt, dma_gnt;
  logic [IDX_W-1:0]      ls_idx, dma_idx;
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_idx;
  logic [0:DATA_W-1]     wr_data;
  logic [0:LINE_BYTES-1] wr_be;
  logic                  unused_addr_off;

  // Byte offset within a line is discarded.
  assign ls_idx          = ls.addr[ADDR_W-1:OFF_W];
  assign dma_idx         = dma.addr[ADDR_W-1:OFF_W];
  assign unused_addr_off = ^{ls.addr[OFF_W-1:0], dma.addr[OFF_W-1:0]};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_CLEAR;
      clear_ptr <= '0;
    end else begin
      state     <= state_nxt;
      clear_ptr <= clear_ptr_nxt;
    end
  end

  // Next state: clear walks every line once; clear_start is only honoured in IDLE.
  always_comb begin
    state_nxt     = state;
    clear_ptr_nxt = clear_ptr;
    case (state)
      ST_CLEAR: begin
        if (clear_ptr == IDX_W'(DEPTH - 1)) begin
          state_nxt     = ST_IDLE;
          clear_ptr_nxt = '0;
        end else begin
          clear_ptr_nxt = clear_ptr + IDX_W'(1);
        end
      end
      ST_IDLE: begin
        if (clear_start) state_nxt = ST_CLEAR;
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  assign idle = (state == ST_IDLE);
  assign busy = (state == ST_CLEAR);

`ifdef LS_DMA_ANTISTARVE_EN
  logic [1:0] starve_cnt;

  // Counts consecutive cycles DMA waited; saturates at 3 until granted or dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 2'd0;
    end else if (!dma.req_valid || dma_gnt) begin
      starve_cnt <= 2'd0;
    end else if (starve_cnt != 2'd3) begin
      starve_cnt <= starve_cnt + 2'd1;
    end
  end

  assign force_dma = (starve_cnt == 2'd3) && dma.req_valid;
`else
  assign force_dma = 1'b0;
`endif

  // Single-access arbitration: ls has priority unless DMA is being forced through.
  assign ls.req_ready  = idle && !force_dma;
  assign dma.req_ready = idle && (force_dma || !ls.req_valid);
  assign ls_gnt        = ls.req_valid && ls.req_ready;
  assign dma_gnt       = dma.req_valid && dma.req_ready;

  // At most one grant per cycle, so a simple select forms the write port.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = ls_idx;
    wr_data = ls.wdata;
    wr_be   = ls.be;
    if (ls_gnt) begin
      wr_en = ls.we;
    end else if (dma_gnt) begin
      wr_en   = dma.we;
      wr_idx  = dma_idx;
      wr_data = dma.wdata;
      wr_be   = dma.be;
    end
  end

  // Storage array: clear has the port during CLEAR, otherwise byte-masked writes.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clear_ptr] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < LINE_BYTES; b++) begin
        if (wr_be[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Registered read paths; rdata holds until the next read on that port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ls.rvalid  <= 1'b0;
      ls.rdata   <= '0;
      dma.rvalid <= 1'b0;
      dma.rdata  <= '0;
    end else begin
      ls.rvalid  <= ls_gnt && !ls.we;
      dma.rvalid <= dma_gnt && !dma.we;
      if (ls_gnt && !ls.we)   ls.rdata  <= mem[ls_idx];
      if (dma_gnt && !dma.we) dma.rdata <= mem[dma_idx];
    end
  end

endmodule

// File: tb/tb_local_store_banked.sv
module tb_local_store_banked;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned LB     = 16;
  localparam int unsigned DW     = LB * 8;
  localparam int unsigned DEPTH  = (2 ** ADDR_W) / LB;
`ifdef LS_DMA_ANTISTARVE_EN
  localparam bit ANTI = 1'b1;
`else
  localparam bit ANTI = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear_start = 1'b0;
  logic busy;

  int n_checks = 0;
  int n_fail   = 0;

  local_store_banked_if #(.ADDR_W(ADDR_W), .LINE_BYTES(LB)) ls_if ();
  local_store_banked_if #(.ADDR_W(ADDR_W), .LINE_BYTES(LB)) dma_if ();

  local_store_banked #(.ADDR_W(ADDR_W), .LINE_BYTES(LB)) dut (
    .clk         (clk),
    .rst         (rst),
    .ls          (ls_if),
    .dma         (dma_if),
    .clear_start (clear_start),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [0:DW-1] m_mem [DEPTH];
  int            m_clear_left;   // cycles of clearing still to do; >0 means busy
  int            m_dma_wait;     // consecutive cycles DMA has waited
  logic          m_ls_rv, m_dma_rv;
  logic [0:DW-1] m_ls_rd, m_dma_rd;

  function automatic void exp_ready(output logic ls_ok, output logic dma_ok);
    logic forced;
    if (m_clear_left > 0) begin
      ls_ok  = 1'b0;
      dma_ok = 1'b0;
    end else begin
      forced = ANTI && (m_dma_wait >= 3) && dma_if.req_valid;
      ls_ok  = !forced;
      dma_ok = forced || !ls_if.req_valid;
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    logic lok, dok, lg, dg;
    int li, di;
    if (rst) begin
      m_clear_left = DEPTH;
      m_dma_wait   = 0;
      m_ls_rv      = 1'b0;
      m_dma_rv     = 1'b0;
      m_ls_rd      = '0;
      m_dma_rd     = '0;
    end else begin
      exp_ready(lok, dok);
      lg = ls_if.req_valid && lok;
      dg = dma_if.req_valid && dok;
      li = int'(ls_if.addr) / LB;
      di = int'(dma_if.addr) / LB;
      m_ls_rv  = lg && !ls_if.we;
      m_dma_rv = dg && !dma_if.we;
      if (m_ls_rv)  m_ls_rd  = m_mem[li];
      if (m_dma_rv) m_dma_rd = m_mem[di];
      for (int b = 0; b < LB; b++) begin
        if (lg && ls_if.we && ls_if.be[b])   m_mem[li][b*8 +: 8] = ls_if.wdata[b*8 +: 8];
        if (dg && dma_if.we && dma_if.be[b]) m_mem[di][b*8 +: 8] = dma_if.wdata[b*8 +: 8];
      end
      if (dma_if.req_valid && !dg) m_dma_wait++;
      else                         m_dma_wait = 0;
      if (m_clear_left > 0) begin
        m_clear_left--;
        if (m_clear_left == 0) for (int l = 0; l < DEPTH; l++) m_mem[l] = '0;
      end else if (clear_start) begin
        m_clear_left = DEPTH;
      end
    end
  end

  // Compare process: every cycle outside reset.
  always @(negedge clk) begin
    logic lok, dok;
    if (!rst) begin
      exp_ready(lok, dok);
      chk("busy", DW'(busy), DW'(m_clear_left > 0));
      chk("ls_req_ready", DW'(ls_if.req_ready), DW'(lok));
      chk("dma_req_ready", DW'(dma_if.req_ready), DW'(dok));
      chk("ls_rvalid", DW'(ls_if.rvalid), DW'(m_ls_rv));
      chk("dma_rvalid", DW'(dma_if.rvalid), DW'(m_dma_rv));
      chk("ls_rdata", ls_if.rdata, m_ls_rd);
      chk("dma_rdata", dma_if.rdata, m_dma_rd);
    end
  end

  // ---------------- driver ----------------
  task automatic set_req(input int port, input logic v, input logic we,
                         input logic [ADDR_W-1:0] addr, input logic [0:DW-1] wd,
                         input logic [0:LB-1] be);
    if (port == 0) begin
      ls_if.req_valid = v; ls_if.we = we; ls_if.addr = addr; ls_if.wdata = wd; ls_if.be = be;
    end else begin
      dma_if.req_valid = v; dma_if.we = we; dma_if.addr = addr; dma_if.wdata = wd; dma_if.be = be;
    end
  endtask

  // Called and returns at #1 after a rising edge; waited = cycles stalled.
  task automatic do_access(input int port, input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [0:DW-1] wd, input logic [0:LB-1] be,
                           output logic [0:DW-1] rd, output int waited);
    bit ok = 0;
    logic rdy;
    waited = 0;
    set_req(port, 1'b1, we, addr, wd, be);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      rdy = (port == 0) ? ls_if.req_ready : dma_if.req_ready;
      if (rdy) begin ok = 1; break; end
      waited++;
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL handshake_timeout: port %0d never ready, required within 64 cycles", port);
    end
    @(posedge clk); #1;
    set_req(port, 1'b0, 1'b0, '0, '0, '0);
    rd = (port == 0) ? ls_if.rdata : dma_if.rdata;
    if (!we && ok) chk("rvalid_after_accept", DW'((port == 0) ? ls_if.rvalid : dma_if.rvalid), DW'(1));
  endtask

  task automatic count_busy(output int cnt, input bit pulse_clear);
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      clear_start = pulse_clear && (cnt == 3 || cnt == 10);
      @(posedge clk); #1;
    end
    clear_start = 1'b0;
  endtask

  localparam logic [0:DW-1] LINE_A  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [0:DW-1] LINE_AP = 128'hA5112233_44556677_8899AABB_CCDDEEA5;
  localparam logic [0:DW-1] ALL_A5  = {16{8'hA5}};
  localparam logic [0:DW-1] ALL_FF  = {16{8'hFF}};

  initial begin
    logic [0:DW-1] rd;
    int w, cnt;
    logic [4:0] dma_hist, ls_stall;
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);

    // Reset release: busy for exactly DEPTH cycles.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    count_busy(cnt, 1'b0);
    chk("reset_busy_cycles", DW'(cnt), DW'(16));

    // Fresh store reads zero.
    do_access(0, 1'b0, 8'h50, '0, '0, rd, w);
    chk("line5_after_reset", rd, '0);

    // Full write then read of the same line with a non-zero byte offset.
    do_access(0, 1'b1, 8'h20, LINE_A, 16'hFFFF, rd, w);
    do_access(0, 1'b0, 8'h2F, '0, '0, rd, w);
    chk("full_write_readback", rd, LINE_A);
    @(posedge clk); #1;
    chk("ls_rvalid_pulse_end", DW'(ls_if.rvalid), DW'(0));
    chk("ls_rdata_holds", ls_if.rdata, LINE_A);

    // Partial write on bytes 0 and 15.
    do_access(0, 1'b1, 8'h20, ALL_A5, 16'h8001, rd, w);
    do_access(0, 1'b0, 8'h20, '0, '0, rd, w);
    chk("partial_write_readback", rd, LINE_AP);

    // Contention for five cycles.
    set_req(0, 1'b1, 1'b0, 8'h20, '0, '0);
    set_req(1, 1'b1, 1'b0, 8'h50, '0, '0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dma_hist[i] = dma_if.req_ready;
      ls_stall[i] = !ls_if.req_ready;
      @(posedge clk); #1;
    end
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    chk("dma_ready_contention", DW'(dma_hist), ANTI ? DW'(5'b01000) : DW'(5'b00000));
    chk("ls_stall_contention", DW'(ls_stall), ANTI ? DW'(5'b01000) : DW'(5'b00000));

    // Fill every line with 0xFF through DMA, spot-check one.
    for (int l = 0; l < DEPTH; l++) do_access(1, 1'b1, ADDR_W'(l * LB), ALL_FF, 16'hFFFF, rd, w);
    do_access(1, 1'b0, 8'h70, '0, '0, rd, w);
    chk("dma_fill_readback", rd, ALL_FF);

    // Clear with a DMA request pending throughout.
    clear_start = 1'b1;
    @(posedge clk); #1;
    clear_start = 1'b0;
    do_access(1, 1'b0, 8'h30, '0, '0, rd, w);
    chk("dma_stall_during_clear", DW'(w), DW'(16));
    chk("dma_read_after_clear", rd, '0);
    for (int l = 0; l < DEPTH; l++) begin
      do_access(0, 1'b0, ADDR_W'(l * LB), '0, '0, rd, w);
      chk($sformatf("line%0d_cleared", l), rd, '0);
    end

    // Reset in the middle of a clear, with ignored clear_start pulses afterwards.
    do_access(0, 1'b1, 8'h90, ALL_A5, 16'hFFFF, rd, w);
    clear_start = 1'b1;
    @(posedge clk); #1;
    clear_start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rdata_zero_after_rst", dma_if.rdata, '0);
    count_busy(cnt, 1'b1);
    chk("midclear_rst_busy_cycles", DW'(cnt), DW'(16));
    do_access(1, 1'b0, 8'h90, '0, '0, rd, w);
    chk("line9_after_reclear", rd, '0);
    chk("dma_no_wait_in_idle", DW'(w), DW'(0));

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/local_store_banked.md
Name: local_store_banked

Overview:
- Parametrised successor local store for the SPU datapath: line-organised SRAM model with two requester ports and a fixed per-cycle access budget.
- Port 0 serves the SPU load/store pipe; port 1 serves DMA/preload.
- Adds a registered read path, per-byte write enables, single-access-per-cycle arbitration, and a multi-cycle hardware clear sequencer, replacing the single-cycle reset wipe.

Parameters:
- ADDR_W, 15, byte-address width. Store size is 2^ADDR_W bytes.
- LINE_BYTES, 16, bytes per line; power of two, minimum 4. DATA_W = LINE_BYTES*8.
- DEPTH, 2^ADDR_W/LINE_BYTES, number of lines (derived; not overridden).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- ls_req_valid  in  1  load/store request valid
- ls_req_ready  out  1  load/store request accepted this cycle when valid
- ls_we  in  1  1 = write, 0 = read
- ls_addr  in  ADDR_W  byte address; low log2(LINE_BYTES) bits ignored
- ls_wdata  in  DATA_W  write line, byte 0 in MSBs [0:7]
- ls_be  in  LINE_BYTES  byte enables, bit 0 = byte 0
- ls_rvalid  out  1  read data valid
- ls_rdata  out  DATA_W  read line
- dma_req_valid, dma_req_ready, dma_we, dma_addr, dma_wdata, dma_be, dma_rvalid, dma_rdata: same widths and meaning for the DMA port
- clear_start  in  1  pulse: zero the whole store
- busy  out  1  clear in progress

Interface facts: clock clk; reset rst, asynchronous, active-high. Bit order is big-endian [0:N-1], matching the SPU datapath.

Behaviour:
- Reset values: ls_rvalid = dma_rvalid = 0; ls_rdata = dma_rdata = 0; state = CLEAR; clear_ptr = 0; busy = 1. Memory contents are not reset directly.
- FSM states: CLEAR and IDLE.
  - CLEAR: writes all-zero to line clear_ptr each cycle, then increments clear_ptr. On clear_ptr == DEPTH-1, the write completes, the FSM goes to IDLE and clear_ptr returns to 0.
  - After rst deasserts, busy stays high for exactly DEPTH cycles.
- clear_start:
  - In IDLE: moves the FSM to CLEAR on the next edge.
  - In CLEAR: ignored.
- rst asserted mid-clear restarts the clear from line 0.
- busy = (state == CLEAR). Both ready outputs are 0 in CLEAR.
- Arbitration, in IDLE, one access per cycle:
  - ls_req_ready = 1.
  - dma_req_ready = !ls_req_valid (fixed priority to ls), unless modified by the optional feature.
  - Ready signals are combinational from valid/state; requesters hold their request until ready.
- Write, accepted at edge N:
  - Line addr[ADDR_W-1 : log2(LINE_BYTES)] is updated only for bytes whose be bit is 1.
  - No response pulse.
- Read, accepted at edge N:
  - rdata is registered at edge N with the line contents before any write at the same edge; no same-edge write can exist under single-access arbitration.
  - rvalid is high for the one cycle after edge N.
  - rdata holds its value until the next read on that port.
- Read after write: a read of the same line accepted at edge N+1 returns the merged data.
- Addresses are line-aligned; there is no wrap-around across lines (the byte offset is discarded).
- clear_start and an accepted request in the same IDLE cycle: the request completes; CLEAR begins on the following edge.

Optional Feature:
- Macro LS_DMA_ANTISTARVE_EN.
- When defined:
  - A 2-bit counter increments each cycle dma_req_valid is high but dma is not granted.
  - It resets to 0 on a DMA grant or when dma_req_valid is low.
  - When the counter reaches 3, the next cycle grants dma: dma_req_ready = 1 and ls_req_ready = 0.
  - The counter then clears.
- When undefined: strict ls priority; DMA can starve indefinitely.

Test Plan:
- Reset release with ADDR_W=8, LINE_BYTES=16 -> busy high exactly 16 cycles; both ready outputs 0 throughout; afterwards a read of line 5 returns all zeros with rvalid one cycle after accept.
- ls write to addr 0x20, data 0x00112233_44556677_8899AABB_CCDDEEFF, be = 0xFFFF, then a read of 0x2F -> returns the same line; ls_rvalid is a 1-cycle pulse.
- Partial write be = 0x8001 with data all 0xA5 over the prior line -> byte 0 and byte 15 read as 0xA5; all other bytes unchanged.
- ls_req_valid and dma_req_valid both held for 5 cycles -> without macro: dma_req_ready = 0 all 5 cycles. With LS_DMA_ANTISTARVE_EN: dma granted on the 4th cycle, ls stalled that cycle.
- clear_start after filling lines 0..15 with 0xFF, then DMA requests during CLEAR -> dma_req_ready stays 0 for 16 cycles; all lines subsequently read 0.
- rst asserted at clear_ptr == 7 for 1 cycle -> busy remains high for a full 16 more cycles after release; clear_start pulses during CLEAR are ignored.
